// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control stage: decodes RV32I instructions into ALU operation codes
// behind a one-entry valid/ready register with flush and a saturating illegal counter.
module alu_ctrl_stage #(
    parameter int OPCODE_LENGTH = 4,
    parameter int INST_WIDTH    = 32,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INST_WIDTH-1:0]    in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] out_op,
    output logic                     out_src_imm,
    output logic                     out_branch,
    output logic                     out_illegal,
    output logic [CNT_WIDTH-1:0]     illegal_cnt
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0101,
        OP_SUB = 4'b0110,
        OP_SLL = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_NE  = 4'b1001,
        OP_GE  = 4'b1010,
        OP_LT  = 4'b1011,
        OP_SLT = 4'b1100,
        OP_SRA = 4'b1110,
        OP_SRL = 4'b1111
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_R      = 7'b0110011,
        OPC_I      = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [INST_WIDTH-1:0] instr_unused;

    assign opcode       = in_instr[6:0];
    assign f3           = in_instr[14:12];
    assign f7           = in_instr[31:25];
    assign instr_unused = in_instr;

    alu_op_e dec_op;
    logic    dec_imm;
    logic    dec_br;
    logic    dec_ill;

    always_comb begin
        dec_op  = OP_AND;
        dec_imm = 1'b0;
        dec_br  = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_R: begin
                if (f7 != F7_ZERO && f7 != F7_ALT) begin
                    dec_ill = 1'b1;
                end else begin
                    case (f3)
                        3'b000: dec_op = f7[5] ? OP_SUB : OP_ADD;
                        3'b111: dec_op = OP_AND;
                        3'b110: dec_op = OP_OR;
                        3'b100: dec_op = OP_XOR;
                        3'b001: if (f7[5]) dec_ill = 1'b1; else dec_op = OP_SLL;
                        3'b010: if (f7[5]) dec_ill = 1'b1; else dec_op = OP_SLT;
                        3'b101: dec_op = f7[5] ? OP_SRA : OP_SRL;
                        default: dec_ill = 1'b1;
                    endcase
                end
            end
            OPC_I: begin
                dec_imm = 1'b1;
                case (f3)
                    3'b000: dec_op = OP_ADD;
                    3'b111: dec_op = OP_AND;
                    3'b110: dec_op = OP_OR;
                    3'b100: dec_op = OP_XOR;
                    3'b010: dec_op = OP_SLT;
                    3'b001: if (f7 == F7_ZERO) dec_op = OP_SLL; else dec_ill = 1'b1;
                    3'b101: begin
                        if (f7 == F7_ZERO)     dec_op = OP_SRL;
                        else if (f7 == F7_ALT) dec_op = OP_SRA;
                        else                   dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR, OPC_LUI, OPC_AUIPC: begin
                dec_op  = OP_ADD;
                dec_imm = 1'b1;
            end
            OPC_JAL: dec_op = OP_ADD;
            OPC_BRANCH: begin
                dec_br = 1'b1;
                case (f3)
                    3'b000:  dec_op = OP_EQ;
                    3'b001:  dec_op = OP_NE;
                    3'b100:  dec_op = OP_LT;
                    3'b101:  dec_op = OP_GE;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal entries always present as a clean AND with no side flags.
        if (dec_ill) begin
            dec_op  = OP_AND;
            dec_imm = 1'b0;
            dec_br  = 1'b0;
        end
    end

    logic                 valid_q, valid_d;
    alu_op_e              op_q, op_d;
    logic                 imm_q, imm_d;
    logic                 br_q, br_d;
    logic                 ill_q, ill_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        imm_d   = imm_q;
        br_d    = br_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            op_d    = dec_op;
            imm_d   = dec_imm;
            br_d    = dec_br;
            ill_d   = dec_ill;
            if (dec_ill && cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            op_q    <= OP_AND;
            imm_q   <= 1'b0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_op      = OPCODE_LENGTH'(op_q);
    assign out_src_imm = imm_q;
    assign out_branch  = br_q;
    assign out_illegal = ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: vector table streamed through a scoreboard queue,
// plus stall, flush, counter saturation and mid-stream reset sequences.
module tb_alu_ctrl_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_op;
    logic        out_src_imm;
    logic        out_branch;
    logic        out_illegal;
    logic [7:0]  illegal_cnt;

    alu_ctrl_stage #(.OPCODE_LENGTH(4), .INST_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_src_imm(out_src_imm), .out_branch(out_branch),
        .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  op;
        logic        imm;
        logic        br;
        logic        ill;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    logic m_valid = 1'b0;
    int   m_cnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [31:0] i, input logic [3:0] o,
                                input logic im, input logic b, input logic il);
        vec_t v;
        v.instr = i; v.op = o; v.imm = im; v.br = b; v.ill = il;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, check current outputs against the model, advance the model.
    task automatic cycle(input logic vld, input vec_t v, input logic ordy, input logic fl);
        logic exp_rdy, acc, cons;
        vec_t h;
        in_valid = vld; in_instr = v.instr; out_ready = ordy; flush = fl;
        #1;
        exp_rdy = !m_valid || ordy;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_valid);
        chk("illegal_cnt", illegal_cnt, m_cnt);
        if (m_valid) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                h = sb[0];
                chk("out_op", out_op, h.op);
                chk("out_src_imm", out_src_imm, h.imm);
                chk("out_branch", out_branch, h.br);
                chk("out_illegal", out_illegal, h.ill);
            end
        end
        acc  = vld && exp_rdy;
        cons = m_valid && ordy;
        @(posedge clk); #1;
        if (cons && sb.size() > 0) void'(sb.pop_front());
        if (fl) begin
            sb.delete();
            m_valid = 1'b0;
        end else if (acc) begin
            sb.push_back(v);
            m_valid = 1'b1;
            if (v.ill && m_cnt != 255) m_cnt++;
        end else if (cons) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFF_FFFF; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        sb.delete(); m_valid = 1'b0; m_cnt = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_out_src_imm", out_src_imm, 0);
        chk("rst_out_branch", out_branch, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_illegal_cnt", illegal_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t idle, add_v, sub_v, bad_v;
        int saved_cnt;
        idle  = mk(32'h0000_0000, 4'h0, 0, 0, 0);
        add_v = mk(32'h0020_81B3, 4'b0010, 0, 0, 0);
        sub_v = mk(32'h4020_81B3, 4'b0110, 0, 0, 0);
        bad_v = mk(32'hFFFF_FFFF, 4'b0000, 0, 0, 1);

        tbl.push_back(add_v);
        tbl.push_back(sub_v);
        tbl.push_back(mk(32'h4030_D093, 4'b1110, 1, 0, 0)); // srai
        tbl.push_back(mk(32'h0020_8463, 4'b1000, 0, 1, 0)); // beq
        tbl.push_back(mk(32'h0020_9463, 4'b1001, 0, 1, 0)); // bne
        tbl.push_back(mk(32'h0020_C463, 4'b1011, 0, 1, 0)); // blt
        tbl.push_back(mk(32'h0020_D463, 4'b1010, 0, 1, 0)); // bge
        tbl.push_back(mk(32'h0020_E463, 4'b0000, 0, 0, 1)); // branch f3=110
        tbl.push_back(mk(32'h0020_A463, 4'b0000, 0, 0, 1)); // branch f3=010
        tbl.push_back(mk(32'h0020_F1B3, 4'b0000, 0, 0, 0)); // and
        tbl.push_back(mk(32'h0020_E1B3, 4'b0001, 0, 0, 0)); // or
        tbl.push_back(mk(32'h0020_C1B3, 4'b0101, 0, 0, 0)); // xor
        tbl.push_back(mk(32'h0020_91B3, 4'b0111, 0, 0, 0)); // sll
        tbl.push_back(mk(32'h0020_A1B3, 4'b1100, 0, 0, 0)); // slt
        tbl.push_back(mk(32'h0020_D1B3, 4'b1111, 0, 0, 0)); // srl
        tbl.push_back(mk(32'h4020_D1B3, 4'b1110, 0, 0, 0)); // sra
        tbl.push_back(mk(32'h0020_B1B3, 4'b0000, 0, 0, 1)); // R f3=011
        tbl.push_back(mk(32'h0220_81B3, 4'b0000, 0, 0, 1)); // R f7=0000001
        tbl.push_back(mk(32'h4020_91B3, 4'b0000, 0, 0, 1)); // sll with f7=0100000
        tbl.push_back(mk(32'h0050_8093, 4'b0010, 1, 0, 0)); // addi
        tbl.push_back(mk(32'h0030_D093, 4'b1111, 1, 0, 0)); // srli
        tbl.push_back(mk(32'h0030_A093, 4'b1100, 1, 0, 0)); // slti
        tbl.push_back(mk(32'h0030_F093, 4'b0000, 1, 0, 0)); // andi
        tbl.push_back(mk(32'h4030_9093, 4'b0000, 0, 0, 1)); // slli bad f7
        tbl.push_back(mk(32'h0230_D093, 4'b0000, 0, 0, 1)); // shift-right bad f7
        tbl.push_back(mk(32'h0030_B093, 4'b0000, 0, 0, 1)); // I f3=011
        tbl.push_back(mk(32'h0000_A083, 4'b0010, 1, 0, 0)); // lw
        tbl.push_back(mk(32'h0010_A023, 4'b0010, 1, 0, 0)); // sw
        tbl.push_back(mk(32'h0000_80E7, 4'b0010, 1, 0, 0)); // jalr
        tbl.push_back(mk(32'h1234_50B7, 4'b0010, 1, 0, 0)); // lui
        tbl.push_back(mk(32'h0000_0097, 4'b0010, 1, 0, 0)); // auipc
        tbl.push_back(mk(32'h0080_00EF, 4'b0010, 0, 0, 0)); // jal
        tbl.push_back(mk(32'h0000_0000, 4'b0000, 0, 0, 1)); // opcode 0
        tbl.push_back(bad_v);

        do_reset();

        // Back-to-back stream of the whole table with the consumer always ready.
        foreach (tbl[i]) cycle(1'b1, tbl[i], 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Stall for 5 cycles with a new word offered, then release.
        cycle(1'b1, add_v, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, sub_v, 1'b0, 1'b0);
        cycle(1'b1, sub_v, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Flush with an accepting illegal word: dropped and not counted.
        saved_cnt = m_cnt;
        cycle(1'b1, bad_v, 1'b1, 1'b1);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_cnt_hold", illegal_cnt, saved_cnt);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Flush of a held entry while stalled.
        cycle(1'b1, add_v, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b0, 1'b0);
        cycle(1'b0, idle, 1'b0, 1'b1);
        cycle(1'b0, idle, 1'b0, 1'b0);

        // Saturate the counter.
        for (int i = 0; i < 300; i++) cycle(1'b1, bad_v, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        chk("cnt_saturated", illegal_cnt, 255);
        cycle(1'b1, bad_v, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        chk("cnt_stays_sat", illegal_cnt, 255);

        // Reset mid-stream with a valid entry held.
        cycle(1'b1, mk(32'h0020_8463, 4'b1000, 0, 1, 0), 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, sub_v, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered ALU-control stage of the RISC-V core. It decodes a 32-bit RV32I instruction into the 4-bit operation code the ALU consumes and presents it through a one-entry valid/ready pipeline register with flush. It sits between fetch/decode and the execute stage, and is the producer side of the ALU `Operation` interface. It also flags unsupported encodings and keeps a saturating count of them.

## Interface
- `OPCODE_LENGTH`, default 4: width of the ALU operation code.
- `INST_WIDTH`, default 32: instruction width.
- `CNT_WIDTH`, default 8: width of the illegal-instruction counter.

- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_instr` is valid.
- `in_ready`  out  1  the stage can accept; combinational, `!out_valid || out_ready`.
- `in_instr`  in  INST_WIDTH  instruction word.
- `flush`  in  1  discard the held entry and any entry accepted this cycle.
- `out_valid`  out  1  decoded entry available.
- `out_ready`  in  1  execute stage consumes the entry.
- `out_op`  out  OPCODE_LENGTH  ALU operation code.
- `out_src_imm`  out  1  ALU SrcB is the immediate (I-type, load, store, JALR, LUI, AUIPC).
- `out_branch`  out  1  conditional branch; the ALU result is the taken flag.
- `out_illegal`  out  1  unsupported encoding; `out_op` = 0000.
- `illegal_cnt`  out  CNT_WIDTH  saturating count of accepted illegal instructions.

## Operation
- Operation codes:
  - AND 0000
  - OR 0001
  - ADD 0010
  - XOR 0101
  - SUB 0110
  - SLL 0111
  - EQ 1000
  - NE 1001
  - GE 1010
  - LT 1011
  - SLT 1100
  - SRA 1110
  - SRL 1111
- Decode fields: opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25].
- R-type (0110011), f7 must be 0000000 or 0100000 (any other value is illegal):
  - 000: ADD if f7[5]=0, SUB if 1.
  - 111 AND; 110 OR; 100 XOR.
  - 001 SLL (f7 must be 0).
  - 010 SLT (f7 must be 0).
  - 101: SRL if f7=0000000, SRA if 0100000.
  - 011: illegal.
- I-ALU (0010011):
  - 000 ADD; 111 AND; 110 OR; 100 XOR; 010 SLT.
  - 001 SLL, requires f7=0000000.
  - 101: SRL if f7=0000000, SRA if 0100000, otherwise illegal.
  - 011: illegal.
  - `out_src_imm`=1.
- Load (0000011), store (0100011), JALR (1100111), LUI (0110111), AUIPC (0010111), JAL (1101111): ADD. `out_src_imm`=1 for all except JAL.
- Branch (1100011):
  - 000 EQ; 001 NE; 100 LT; 101 GE.
  - Any other f3: illegal.
  - `out_branch`=1 only for legal branches.
- Any other opcode: illegal. An illegal entry has `out_op`=0000, `out_src_imm`=0, `out_branch`=0.
- Accept = `in_valid && in_ready`. On an accept without flush, the register loads the decoded fields and `out_valid` is 1 next cycle.
- If `out_valid && out_ready` with no new accept, `out_valid` is 0 next cycle; the data fields hold their last value.
- `flush`=1: `out_valid` is 0 next cycle regardless of accept or consume. A same-cycle accept is dropped and not counted.
- `illegal_cnt` increments by 1 on each non-flushed accept of an illegal instruction and saturates at 2^CNT_WIDTH−1.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- Stall: while `out_valid && !out_ready`, `in_ready`=0 and all `out_*` hold stable.
- Reset values: `out_valid` 0, `out_op` 0000, `out_src_imm` 0, `out_branch` 0, `out_illegal` 0, `illegal_cnt` 0.
- `reset` dominates `flush` and accept. `in_ready` is 1 in the cycle after reset.
- A simultaneous consume and accept replaces the entry back-to-back; `out_valid` stays 1.
- The counter at maximum with another illegal accept holds at maximum.

## Test plan
- After reset, stream `add x3,x1,x2` (0x002081B3), `sub` (0x402081B3), `srai x1,x1,3` (0x4030D093) with `out_ready`=1 -> over three consecutive cycles, `out_op` 0010, 0110, 1110; `out_src_imm` 0, 0, 1; `out_valid` high continuously.
- `beq` (0x00208463), `bne` (0x00209463), `blt` (0x0020C463), `bge` (0x0020D463) -> `out_op` 1000, 1001, 1011, 1010 with `out_branch`=1. Then f3=110 (0x0020E463) -> `out_illegal`=1, `out_op` 0000, `illegal_cnt` 1.
- Hold `out_ready`=0 for 5 cycles with an entry present -> `in_ready`=0 and outputs frozen. Release -> the entry is consumed and the next accept occurs the same cycle.
- Assert `flush` together with an accepting `in_valid` -> `out_valid`=0 next cycle; an illegal word presented that cycle leaves `illegal_cnt` unchanged.
- Feed 300 illegal words (0xFFFFFFFF) -> `illegal_cnt` = 255 and stays there.
- Assert `reset` mid-stream with `out_valid`=1 -> next cycle all outputs are at their reset values and `in_ready`=1.
